// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between a data cache (requester 0)
// and an instruction cache (requester 1), using single-cycle start/finish pulse handshakes.
`timescale 1ns/1ps
module cache_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic                  R0ReadStart,
   input  logic                  R0WriteStart,
   input  logic [ADDR_WIDTH-1:0] R0ReadAddr,
   input  logic [ADDR_WIDTH-1:0] R0WriteAddr,
   input  logic [DATA_WIDTH-1:0] R0WriteData,
   output logic [DATA_WIDTH-1:0] R0ReadData,
   output logic                  R0ReadFinish,
   output logic                  R0WriteFinish,
   input  logic                  R1ReadStart,
   input  logic                  R1WriteStart,
   input  logic [ADDR_WIDTH-1:0] R1ReadAddr,
   input  logic [ADDR_WIDTH-1:0] R1WriteAddr,
   input  logic [DATA_WIDTH-1:0] R1WriteData,
   output logic [DATA_WIDTH-1:0] R1ReadData,
   output logic                  R1ReadFinish,
   output logic                  R1WriteFinish,
   output logic                  MemStart,
   output logic                  MemWE,
   output logic [ADDR_WIDTH-1:0] MemAddr,
   output logic [DATA_WIDTH-1:0] MemWData,
   input  logic [DATA_WIDTH-1:0] MemRData,
   input  logic                  MemDone
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

   state_t                r_state;
   logic                  r_ptr;
   logic                  r_owner;
   logic                  r_op_wr;
   logic                  r_mem_start;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic [DATA_WIDTH-1:0] r_r0_rdata;
   logic [DATA_WIDTH-1:0] r_r1_rdata;
   logic                  r_r0_rfin;
   logic                  r_r0_wfin;
   logic                  r_r1_rfin;
   logic                  r_r1_wfin;

   logic                  r_r0rd_pend;
   logic                  r_r0wr_pend;
   logic                  r_r1rd_pend;
   logic                  r_r1wr_pend;
   logic [ADDR_WIDTH-1:0] r_r0rd_addr;
   logic [ADDR_WIDTH-1:0] r_r0wr_addr;
   logic [DATA_WIDTH-1:0] r_r0wr_data;
   logic [ADDR_WIDTH-1:0] r_r1rd_addr;
   logic [ADDR_WIDTH-1:0] r_r1wr_addr;
   logic [DATA_WIDTH-1:0] r_r1wr_data;

   logic                  w_r0_pend;
   logic                  w_r1_pend;
   logic                  w_sel;
   logic                  w_sel_wr;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_wdata;
   logic                  w_resp;

   assign w_r0_pend = r_r0rd_pend | r_r0wr_pend;
   assign w_r1_pend = r_r1rd_pend | r_r1wr_pend;
   // Pointer breaks ties only; a lone pending requester always wins.
   assign w_sel     = (w_r0_pend && w_r1_pend) ? r_ptr : w_r1_pend;
   // Write before read keeps writeback-then-refill order within a requester.
   assign w_sel_wr  = w_sel ? r_r1wr_pend : r_r0wr_pend;

   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      unique case ({w_sel, w_sel_wr})
         2'b00: w_sel_addr = r_r0rd_addr;
         2'b01: begin
            w_sel_addr  = r_r0wr_addr;
            w_sel_wdata = r_r0wr_data;
         end
         2'b10: w_sel_addr = r_r1rd_addr;
         2'b11: begin
            w_sel_addr  = r_r1wr_addr;
            w_sel_wdata = r_r1wr_data;
         end
         default: ;
      endcase
   end

   assign w_resp = (r_state == StResp);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_r0rd_pend <= 1'b0;
         r_r0wr_pend <= 1'b0;
         r_r1rd_pend <= 1'b0;
         r_r1wr_pend <= 1'b0;
         r_r0rd_addr <= '0;
         r_r0wr_addr <= '0;
         r_r0wr_data <= '0;
         r_r1rd_addr <= '0;
         r_r1wr_addr <= '0;
         r_r1wr_data <= '0;
      end else begin
         if (R0ReadStart && !r_r0rd_pend) begin
            r_r0rd_pend <= 1'b1;
            r_r0rd_addr <= R0ReadAddr;
         end
         if (R0WriteStart && !r_r0wr_pend) begin
            r_r0wr_pend <= 1'b1;
            r_r0wr_addr <= R0WriteAddr;
            r_r0wr_data <= R0WriteData;
         end
         if (R1ReadStart && !r_r1rd_pend) begin
            r_r1rd_pend <= 1'b1;
            r_r1rd_addr <= R1ReadAddr;
         end
         if (R1WriteStart && !r_r1wr_pend) begin
            r_r1wr_pend <= 1'b1;
            r_r1wr_addr <= R1WriteAddr;
            r_r1wr_data <= R1WriteData;
         end
         // The finishing slot is still occupied this cycle, so its own start is ignored.
         if (w_resp && !r_owner && !r_op_wr) r_r0rd_pend <= 1'b0;
         if (w_resp && !r_owner &&  r_op_wr) r_r0wr_pend <= 1'b0;
         if (w_resp &&  r_owner && !r_op_wr) r_r1rd_pend <= 1'b0;
         if (w_resp &&  r_owner &&  r_op_wr) r_r1wr_pend <= 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state     <= StIdle;
         r_ptr       <= 1'b0;
         r_owner     <= 1'b0;
         r_op_wr     <= 1'b0;
         r_mem_start <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_r0_rdata  <= '0;
         r_r1_rdata  <= '0;
         r_r0_rfin   <= 1'b0;
         r_r0_wfin   <= 1'b0;
         r_r1_rfin   <= 1'b0;
         r_r1_wfin   <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_r0_pend || w_r1_pend) begin
                  r_owner     <= w_sel;
                  r_op_wr     <= w_sel_wr;
                  r_mem_we    <= w_sel_wr;
                  r_mem_addr  <= w_sel_addr;
                  r_mem_wdata <= w_sel_wdata;
                  r_mem_start <= 1'b1;
                  r_state     <= StIssue;
               end
            end
            StIssue: begin
               r_mem_start <= 1'b0;
               r_state     <= StWait;
            end
            StWait: begin
               if (MemDone) begin
                  if (!r_op_wr && !r_owner) r_r0_rdata <= MemRData;
                  if (!r_op_wr &&  r_owner) r_r1_rdata <= MemRData;
                  r_r0_rfin <= !r_owner && !r_op_wr;
                  r_r0_wfin <= !r_owner &&  r_op_wr;
                  r_r1_rfin <=  r_owner && !r_op_wr;
                  r_r1_wfin <=  r_owner &&  r_op_wr;
                  r_state   <= StResp;
               end
            end
            StResp: begin
               r_r0_rfin <= 1'b0;
               r_r0_wfin <= 1'b0;
               r_r1_rfin <= 1'b0;
               r_r1_wfin <= 1'b0;
               r_ptr     <= ~r_owner;
               r_state   <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign MemStart      = r_mem_start;
   assign MemWE         = r_mem_we;
   assign MemAddr       = r_mem_addr;
   assign MemWData      = r_mem_wdata;
   assign R0ReadData    = r_r0_rdata;
   assign R1ReadData    = r_r1_rdata;
   assign R0ReadFinish  = r_r0_rfin;
   assign R0WriteFinish = r_r0_wfin;
   assign R1ReadFinish  = r_r1_rfin;
   assign R1WriteFinish = r_r1_wfin;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a memory model answers MemStart, and a scoreboard of
// expected memory ops and finish pulses is checked as the DUT produces them.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        R0ReadStart, R0WriteStart, R1ReadStart, R1WriteStart;
   logic [31:0] R0ReadAddr, R0WriteAddr, R0WriteData, R1ReadAddr, R1WriteAddr, R1WriteData;
   logic [31:0] R0ReadData, R1ReadData;
   logic        R0ReadFinish, R0WriteFinish, R1ReadFinish, R1WriteFinish;
   logic        MemStart, MemWE, MemDone;
   logic [31:0] MemAddr, MemWData, MemRData;

   cache_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .CLK(CLK), .Reset(Reset),
      .R0ReadStart(R0ReadStart), .R0WriteStart(R0WriteStart),
      .R0ReadAddr(R0ReadAddr), .R0WriteAddr(R0WriteAddr), .R0WriteData(R0WriteData),
      .R0ReadData(R0ReadData), .R0ReadFinish(R0ReadFinish), .R0WriteFinish(R0WriteFinish),
      .R1ReadStart(R1ReadStart), .R1WriteStart(R1WriteStart),
      .R1ReadAddr(R1ReadAddr), .R1WriteAddr(R1WriteAddr), .R1WriteData(R1WriteData),
      .R1ReadData(R1ReadData), .R1ReadFinish(R1ReadFinish), .R1WriteFinish(R1WriteFinish),
      .MemStart(MemStart), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
      .MemRData(MemRData), .MemDone(MemDone)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } txn_t;

   txn_t        exp_mem[$];
   txn_t        exp_fin[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          mem_delay = 1;
   logic        inflight = 1'b0;
   logic        hold_we;
   logic [31:0] hold_addr, hold_wdata;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a == 32'h40) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'h1357);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic push(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input int c);
      txn_t t;
      t.req = req; t.we = we; t.addr = addr; t.data = data; t.cyc = c;
      exp_mem.push_back(t);
      exp_fin.push_back(t);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_fin.size() != 0 || exp_mem.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check("drain_timeout", exp_fin.size(), 0);
      repeat (3) tick();
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
      tick();
   endtask

   // Memory model: answers each MemStart after mem_delay cycles unless reset intervenes.
   initial begin
      logic [31:0] a;
      logic        we, aborted;
      MemDone  = 1'b0;
      MemRData = '0;
      forever begin
         @(negedge CLK);
         if (MemStart && !Reset) begin
            a = MemAddr;
            we = MemWE;
            aborted = 1'b0;
            for (int i = 0; i < mem_delay; i++) begin
               @(negedge CLK);
               if (Reset) aborted = 1'b1;
            end
            if (!aborted) begin
               MemDone  = 1'b1;
               MemRData = we ? 32'hBAD0BAD0 : mem_val(a);
               @(negedge CLK);
               MemDone  = 1'b0;
            end
         end
      end
   end

   // Scoreboard consumer.
   always @(negedge CLK) begin
      txn_t       e;
      logic [3:0] fin, want;
      if (Reset) begin
         exp_mem.delete();
         exp_fin.delete();
         inflight = 1'b0;
      end else begin
         if (MemStart) begin
            if (exp_mem.size() == 0) begin
               check("spurious_memstart", {31'b0, MemStart}, 32'd0);
            end else begin
               e = exp_mem.pop_front();
               check("mem_we", {31'b0, MemWE}, {31'b0, e.we});
               check("mem_addr", MemAddr, e.addr);
               if (e.we) check("mem_wdata", MemWData, e.data);
               if (e.cyc >= 0) check("memstart_cycle", cyc, e.cyc + 2);
               inflight   = 1'b1;
               hold_we    = MemWE;
               hold_addr  = MemAddr;
               hold_wdata = MemWData;
            end
         end else if (inflight) begin
            check("hold_we", {31'b0, MemWE}, {31'b0, hold_we});
            check("hold_addr", MemAddr, hold_addr);
            check("hold_wdata", MemWData, hold_wdata);
         end
         fin = {R1ReadFinish, R1WriteFinish, R0ReadFinish, R0WriteFinish};
         if (fin != 4'b0) begin
            inflight = 1'b0;
            if (exp_fin.size() == 0) begin
               check("spurious_finish", {28'b0, fin}, 32'd0);
            end else begin
               e = exp_fin.pop_front();
               want = 4'b0001 << {e.req, ~e.we};
               check("finish_kind", {28'b0, fin}, {28'b0, want});
               if (!e.we) check("read_data", e.req ? R1ReadData : R0ReadData, mem_val(e.addr));
               if (e.cyc >= 0) check("finish_cycle", cyc, e.cyc + 4);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int  n;
      int  c0, c1;
      bit  re0, re1;
      Reset = 1'b1;
      R0ReadStart = 0; R0WriteStart = 0; R1ReadStart = 0; R1WriteStart = 0;
      R0ReadAddr = 0; R0WriteAddr = 0; R0WriteData = 0;
      R1ReadAddr = 0; R1WriteAddr = 0; R1WriteData = 0;
      repeat (3) tick();
      check("rst_memstart", {31'b0, MemStart}, 32'd0);
      check("rst_memwe", {31'b0, MemWE}, 32'd0);
      check("rst_memaddr", MemAddr, 32'd0);
      check("rst_memwdata", MemWData, 32'd0);
      check("rst_r0rdata", R0ReadData, 32'd0);
      check("rst_r1rdata", R1ReadData, 32'd0);
      check("rst_finish", {28'b0, R1ReadFinish, R1WriteFinish, R0ReadFinish, R0WriteFinish}, 0);
      Reset = 1'b0;
      tick();

      // Single read with latency check.
      n = cyc;
      R0ReadStart = 1; R0ReadAddr = 32'h40;
      push(1'b0, 1'b0, 32'h40, 32'h0, n);
      tick();
      R0ReadStart = 0;
      drain(30);

      // Simultaneous reads after reset: R0 first, then pointer returns to R0.
      do_reset();
      R0ReadStart = 1; R0ReadAddr = 32'h100;
      R1ReadStart = 1; R1ReadAddr = 32'h200;
      push(1'b0, 1'b0, 32'h100, 32'h0, -1);
      push(1'b1, 1'b0, 32'h200, 32'h0, -1);
      tick();
      R0ReadStart = 0; R1ReadStart = 0;
      drain(40);
      R0ReadStart = 1; R0ReadAddr = 32'h140;
      R1ReadStart = 1; R1ReadAddr = 32'h240;
      push(1'b0, 1'b0, 32'h140, 32'h0, -1);
      push(1'b1, 1'b0, 32'h240, 32'h0, -1);
      tick();
      R0ReadStart = 0; R1ReadStart = 0;
      drain(40);

      // Writeback before refill for the same requester.
      R0WriteStart = 1; R0WriteAddr = 32'h80; R0WriteData = 32'h12345678;
      R0ReadStart = 1; R0ReadAddr = 32'hC0;
      push(1'b0, 1'b1, 32'h80, 32'h12345678, -1);
      push(1'b0, 1'b0, 32'hC0, 32'h0, -1);
      tick();
      R0WriteStart = 0; R0ReadStart = 0;
      drain(40);

      // Fairness: both requesters re-issue reads on every finish, 8 transactions in total.
      do_reset();
      c0 = 1; c1 = 1; re0 = 0; re1 = 0;
      R0ReadStart = 1; R0ReadAddr = 32'h1000;
      R1ReadStart = 1; R1ReadAddr = 32'h2000;
      push(1'b0, 1'b0, 32'h1000, 32'h0, -1);
      push(1'b1, 1'b0, 32'h2000, 32'h0, -1);
      for (int k = 0; k < 200 && (exp_fin.size() != 0 || re0 || re1); k++) begin
         tick();
         R0ReadStart = 0; R1ReadStart = 0;
         if (re0) begin
            R0ReadStart = 1; R0ReadAddr = 32'h1000 + 32'(c0) * 32'h10;
            push(1'b0, 1'b0, R0ReadAddr, 32'h0, -1);
            c0++; re0 = 0;
         end
         if (re1) begin
            R1ReadStart = 1; R1ReadAddr = 32'h2000 + 32'(c1) * 32'h10;
            push(1'b1, 1'b0, R1ReadAddr, 32'h0, -1);
            c1++; re1 = 0;
         end
         if (R0ReadFinish && c0 < 4) re0 = 1;
         if (R1ReadFinish && c1 < 4) re1 = 1;
      end
      R0ReadStart = 0; R1ReadStart = 0;
      check("fair_r0_count", c0, 4);
      check("fair_r1_count", c1, 4);
      drain(40);

      // Slow memory with a duplicate write start during WAIT.
      mem_delay = 10;
      R1WriteStart = 1; R1WriteAddr = 32'h300; R1WriteData = 32'hCAFEF00D;
      push(1'b1, 1'b1, 32'h300, 32'hCAFEF00D, -1);
      tick();
      R1WriteStart = 0;
      repeat (5) tick();
      R1WriteStart = 1; R1WriteAddr = 32'h340; R1WriteData = 32'h11111111;
      tick();
      R1WriteStart = 0;
      drain(60);
      repeat (6) tick();

      // Reset in the middle of WAIT: everything clears and no finish follows.
      R0ReadStart = 1; R0ReadAddr = 32'h500;
      push(1'b0, 1'b0, 32'h500, 32'h0, -1);
      tick();
      R0ReadStart = 0;
      repeat (4) tick();
      Reset = 1'b1;
      #1;
      check("midrst_memstart", {31'b0, MemStart}, 32'd0);
      check("midrst_memwe", {31'b0, MemWE}, 32'd0);
      check("midrst_memaddr", MemAddr, 32'd0);
      check("midrst_memwdata", MemWData, 32'd0);
      check("midrst_r0rdata", R0ReadData, 32'd0);
      check("midrst_r1rdata", R1ReadData, 32'd0);
      tick();
      tick();
      Reset = 1'b0;
      mem_delay = 1;
      repeat (15) tick();
      n = cyc;
      R0ReadStart = 1; R0ReadAddr = 32'h600;
      push(1'b0, 1'b0, 32'h600, 32'h0, n);
      tick();
      R0ReadStart = 0;
      drain(30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one backing-memory port between two cache controllers: requester 0 (data cache) and requester 1 (instruction cache).
- Captures each requester's single-cycle read/write start pulses and grants the memory port round-robin.
- Issues a single-cycle start pulse downstream, waits for the memory's completion pulse, then returns data and a one-cycle finish pulse to the owning requester.
- Sits between the cache blocks' Mem* handshake ports and the data memory/BRAM wrapper.

Parameters:
- ADDR_WIDTH, 32, width of all memory addresses.
- DATA_WIDTH, 32, width of all memory data words.

Ports:
- CLK  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- R0ReadStart  input  1  requester 0 read start pulse.
- R0WriteStart  input  1  requester 0 write start pulse.
- R0ReadAddr  input  ADDR_WIDTH  requester 0 read address, valid with R0ReadStart.
- R0WriteAddr  input  ADDR_WIDTH  requester 0 write address, valid with R0WriteStart.
- R0WriteData  input  DATA_WIDTH  requester 0 write data, valid with R0WriteStart.
- R0ReadData  output  DATA_WIDTH  read data returned to requester 0.
- R0ReadFinish  output  1  requester 0 read done pulse.
- R0WriteFinish  output  1  requester 0 write done pulse.
- R1ReadStart, R1WriteStart, R1ReadAddr, R1WriteAddr, R1WriteData, R1ReadData, R1ReadFinish, R1WriteFinish: same directions, widths and meaning for requester 1.
- MemStart  output  1  downstream start pulse.
- MemWE  output  1  1 = write, 0 = read; held through the transaction.
- MemAddr  output  ADDR_WIDTH  downstream address; held through the transaction.
- MemWData  output  DATA_WIDTH  downstream write data; held through the transaction.
- MemRData  input  DATA_WIDTH  downstream read data, valid with MemDone.
- MemDone  input  1  downstream completion pulse.

Behaviour:
- Reset values: all outputs 0, pending slots cleared, FSM in IDLE, round-robin pointer = requester 0.
- Capture: four pending slots (R0rd, R0wr, R1rd, R1wr).
  - Each slot latches its address (and data, for writes) on the cycle its start pulse is high.
  - A start pulse on an already-occupied slot is ignored; the first capture is kept.
  - A slot clears in the cycle its finish pulse is issued.
- Same requester with both read and write pending: write is issued first. This preserves cache writeback-then-refill order.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any slot is pending, select a requester round-robin. The pointer requester wins ties; if only one requester is pending, it wins. Latch the selected op into the Mem* registers and go to ISSUE.
  - A start captured in cycle N is eligible in IDLE at N+1, not at N.
  - ISSUE: MemStart = 1 for exactly one cycle, then go to WAIT.
  - WAIT: hold MemWE, MemAddr and MemWData stable. When MemDone = 1, latch MemRData on reads and go to RESP.
  - RESP: pulse the owner's ReadFinish or WriteFinish for one cycle. On reads, the owner's ReadData is updated in the same cycle and then held until that requester's next read. Clear the slot, advance the pointer to the other requester, return to IDLE.
- Latency with an idle arbiter and MemDone at the first WAIT cycle:
  - start at cycle N;
  - MemStart at N+2;
  - MemDone at N+3;
  - finish at N+4.
- MemDone outside WAIT is ignored.
- Both requesters pending continuously: service alternates R0, R1, R0, ... No starvation; at most one transaction of the other requester intervenes.
- Reset asserted mid-transaction: immediate return to reset state. Pending slots are lost and no finish pulse is issued. Requesters must re-issue.
- A new start pulse on a free slot arriving during RESP or WAIT is captured normally.

Test Plan:
- Single read: R0ReadStart with addr 0x00000040; memory returns 0xDEADBEEF with MemDone one cycle after MemStart. Required: MemStart at N+2 with MemWE = 0 and MemAddr 0x40; R0ReadFinish at N+4 with R0ReadData = 0xDEADBEEF; R1 finish outputs stay 0.
- Simultaneous requests: R0ReadStart (0x100) and R1ReadStart (0x200) in the same cycle after reset. Required: 0x100 is served first; R1ReadFinish occurs after R0ReadFinish; the next tie goes to R0 only after R1 has been served.
- Writeback order: R0WriteStart (0x80, 0x12345678) and R0ReadStart (0xC0) in the same cycle. Required: the first MemStart has MemWE = 1, MemAddr 0x80, MemWData 0x12345678; the second has MemWE = 0, MemAddr 0xC0; two separate finish pulses in that order.
- Fairness: R0 and R1 re-issue reads every time their finish arrives, for 8 transactions. Required: the MemAddr sequence strictly alternates between R0 and R1 addresses.
- Slow memory and duplicate start: MemDone delayed 10 cycles; R1WriteStart is re-pulsed during WAIT with different data. Required: MemAddr, MemWData and MemWE are stable through WAIT; the duplicate start is ignored; exactly one R1WriteFinish.
- Reset mid-WAIT: assert Reset during WAIT, then release. Required: all outputs are 0 immediately; no finish pulse follows; a new R0ReadStart afterwards completes normally.
